seg7_scroll_ctrl: RTL and testbench

Parametrised multiplexed seven-segment display controller with an internal, writable message buffer. It supports static, scroll-left, scroll-right and blink modes. It replaces the fixed 4-digit scroll and slow-clock pairing with a single-clock block that uses clock-enable ticks, so no derived clocks exist. It sits between user/control logic and the board's active-low segment and anode pins.

---
 rtl/seg7_scroll_ctrl.sv | 163 ++++++++++++++++
 tb/tb_seg7_scroll_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scroll_ctrl.sv
// Multiplexed seven-segment display controller with a writable message buffer.
// Runs entirely on clk: refresh and scroll timing come from clock-enable ticks,
// so no derived clocks exist. Supports static, scroll-left, scroll-right and
// blink modes. Segment and anode pins are active-low and registered.
module seg7_scroll_ctrl #(
    parameter int N_DIGITS    = 4,
    parameter int MSG_LEN     = 16,
    parameter int REFRESH_DIV = 100000,
    parameter int SCROLL_DIV  = 25000000,
    localparam int AW         = $clog2(MSG_LEN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [4:0]          wr_data,
    output logic [6:0]          seg_L,
    output logic [N_DIGITS-1:0] anode_L
);

    localparam int DW = $clog2(N_DIGITS);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(SCROLL_DIV);

    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] SCR_LAST = SW'(SCROLL_DIV - 1);
    localparam logic [DW-1:0] DIG_LAST = DW'(N_DIGITS - 1);
    localparam logic [AW-1:0] OFF_LAST = AW'(MSG_LEN - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_LEFT   = 2'b01;
    localparam logic [1:0] MODE_RIGHT  = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    logic [RW-1:0] ref_cnt;
    logic [SW-1:0] scr_cnt;
    logic          ref_tick;
    logic          scr_tick;
    logic [DW-1:0] digit;
    logic [AW-1:0] offset;
    logic          phase;
    logic [4:0]    msg_buf [MSG_LEN];
    logic [AW:0]   rd_sum;
    logic [AW-1:0] rd_idx;
    logic          wr_ok;

    // Character code to active-low {g,f,e,d,c,b,a}; 16 and 18-31 are blank.
    function automatic logic [6:0] glyph(input logic [4:0] code);
        logic [6:0] s;
        s = SEG_BLANK;
        case (code)
            5'd0:  s = 7'h40;
            5'd1:  s = 7'h79;
            5'd2:  s = 7'h24;
            5'd3:  s = 7'h30;
            5'd4:  s = 7'h19;
            5'd5:  s = 7'h12;
            5'd6:  s = 7'h02;
            5'd7:  s = 7'h78;
            5'd8:  s = 7'h00;
            5'd9:  s = 7'h10;
            5'd10: s = 7'h08;
            5'd11: s = 7'h03;
            5'd12: s = 7'h46;
            5'd13: s = 7'h21;
            5'd14: s = 7'h06;
            5'd15: s = 7'h0E;
            5'd17: s = 7'h3F;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign ref_tick = (ref_cnt == REF_LAST);
    assign scr_tick = (scr_cnt == SCR_LAST);
    assign wr_ok    = wr_en && (int'(wr_addr) < MSG_LEN);

    // Free-running refresh and scroll dividers, independent of en and mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt <= '0;
            scr_cnt <= '0;
        end else begin
            ref_cnt <= ref_tick ? '0 : ref_cnt + RW'(1);
            scr_cnt <= scr_tick ? '0 : scr_cnt + SW'(1);
        end
    end

    // Digit multiplexing index advances once per refresh tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= '0;
        end else if (ref_tick) begin
            digit <= (digit == DIG_LAST) ? '0 : digit + DW'(1);
        end
    end

    // Scroll offset and blink phase move only on enabled scroll ticks, so a
    // mode change (including leaving blink while blanked) lands on the next tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            offset <= '0;
            phase  <= 1'b0;
        end else if (scr_tick && en) begin
            case (mode)
                MODE_LEFT: begin
                    offset <= (offset == OFF_LAST) ? '0 : offset + AW'(1);
                    phase  <= 1'b0;
                end
                MODE_RIGHT: begin
                    offset <= (offset == '0) ? OFF_LAST : offset - AW'(1);
                    phase  <= 1'b0;
                end
                MODE_BLINK: begin
                    phase  <= ~phase;
                end
                default: begin
                    phase  <= 1'b0;
                end
            endcase
        end
    end

    // Message buffer: reset fills with blanks; reset wins over a concurrent write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_buf[i] <= 5'd16;
            end
        end else if (wr_ok) begin
            msg_buf[wr_addr] <= wr_data;
        end
    end

    // Buffer slot for the active digit: offset + (N_DIGITS-1-digit) mod MSG_LEN.
    // Both addends are below MSG_LEN, so one conditional subtract suffices.
    always_comb begin
        rd_sum = {1'b0, offset} + (AW+1)'(N_DIGITS - 1) - (AW+1)'(digit);
        if (rd_sum >= (AW+1)'(MSG_LEN)) begin
            rd_sum = rd_sum - (AW+1)'(MSG_LEN);
        end
        rd_idx = rd_sum[AW-1:0];
    end

    // Registered pin drive; blink-off phase blanks segments and all anodes.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_L   <= SEG_BLANK;
            anode_L <= '1;
        end else if (phase) begin
            seg_L   <= SEG_BLANK;
            anode_L <= '1;
        end else begin
            seg_L   <= glyph(msg_buf[rd_idx]);
            anode_L <= ~(N_DIGITS'(1) << digit);
        end
    end

endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// Bench for seg7_scroll_ctrl: behavioural model checked every cycle, a glyph
// vector table, directed multi-cycle sequences and a randomized phase.
module tb_seg7_scroll_ctrl;

    localparam int ND = 4;
    localparam int ML = 8;
    localparam int RD = 4;
    localparam int SD = 64;

    logic          clk;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [4:0]    wr_data;
    logic [6:0]    seg_L;
    logic [ND-1:0] anode_L;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scroll_ctrl #(
        .N_DIGITS(ND), .MSG_LEN(ML), .REFRESH_DIV(RD), .SCROLL_DIV(SD)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .seg_L(seg_L), .anode_L(anode_L)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] code;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs[21];

    function automatic logic [6:0] ref_glyph(input int c);
        case (c)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            10: return 7'b0001000; 11: return 7'b0000011;
            12: return 7'b1000110; 13: return 7'b0100001;
            14: return 7'b0000110; 15: return 7'b0001110;
            17: return 7'b0111111;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    int         m_rc, m_sc, m_dig, m_off, m_ph, m_ticks;
    int         m_buf[ML];
    bit         model_valid = 1'b0;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;

    initial begin
        m_ticks = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_seg = 7'h7F;
                exp_an  = 4'hF;
                m_rc = 0; m_sc = 0; m_dig = 0; m_off = 0; m_ph = 0;
                foreach (m_buf[k]) m_buf[k] = 16;
                model_valid = 1'b1;
            end else if (model_valid) begin
                if (m_ph != 0) begin
                    exp_seg = 7'h7F;
                    exp_an  = 4'hF;
                end else begin
                    exp_seg = ref_glyph(m_buf[(m_off + ND - 1 - m_dig) % ML]);
                    exp_an  = 4'hF & ~(4'b1 << m_dig);
                end
                if (wr_en && int'(wr_addr) < ML) m_buf[wr_addr] = int'(wr_data);
                m_rc = (m_rc + 1) % RD;
                if (m_rc == 0) m_dig = (m_dig + 1) % ND;
                m_sc = (m_sc + 1) % SD;
                if (m_sc == 0) begin
                    m_ticks++;
                    if (en) begin
                        if (mode == 2'b01) m_off = (m_off + 1) % ML;
                        if (mode == 2'b10) m_off = (m_off + ML - 1) % ML;
                        m_ph = (mode == 2'b11) ? 1 - m_ph : 0;
                    end
                end
            end
        end
    end

    // Continuous comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                chk("model_seg", seg_L, exp_seg);
                chk("model_an", anode_L, exp_an);
            end
        end
    end

    // ---------------- helpers (called at negedge) ----------------
    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = 5'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] a);
        int k;
        k = 0;
        while (anode_L == a && k < 40) begin @(negedge clk); k++; end
        k = 0;
        while (anode_L != a && k < 40) begin @(negedge clk); k++; end
        if (anode_L != a) timeout("wait_anode");
    endtask

    task automatic left_seg(output logic [6:0] s);
        wait_an(4'b0111);
        s = seg_L;
    endtask

    task automatic wait_stick(input int n);
        int t0, k;
        t0 = m_ticks;
        k  = 0;
        while (m_ticks < t0 + n && k < n * SD + 8) begin @(negedge clk); k++; end
        if (m_ticks < t0 + n) timeout("wait_scroll_tick");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [6:0] s;
        logic [3:0] seen;

        vecs = '{
            '{5'd0, 7'b1000000}, '{5'd1, 7'b1111001}, '{5'd2, 7'b0100100},
            '{5'd3, 7'b0110000}, '{5'd4, 7'b0011001}, '{5'd5, 7'b0010010},
            '{5'd6, 7'b0000010}, '{5'd7, 7'b1111000}, '{5'd8, 7'b0000000},
            '{5'd9, 7'b0010000}, '{5'd10, 7'b0001000}, '{5'd11, 7'b0000011},
            '{5'd12, 7'b1000110}, '{5'd13, 7'b0100001}, '{5'd14, 7'b0000110},
            '{5'd15, 7'b0001110}, '{5'd16, 7'h7F}, '{5'd17, 7'b0111111},
            '{5'd18, 7'h7F}, '{5'd25, 7'h7F}, '{5'd31, 7'h7F}
        };

        rst = 1'b1; en = 1'b0; mode = 2'b00;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // 1: reset state and first refresh tick
        @(negedge clk);
        chk("rst_seg", seg_L, 7'h7F);
        chk("rst_an", anode_L, 4'hF);
        rst = 1'b0;
        @(negedge clk);
        chk("first_an", anode_L, 4'hE);
        chk("first_seg", seg_L, 7'h7F);
        repeat (3) @(negedge clk);
        chk("digit0_hold", anode_L, 4'hE);
        @(negedge clk);
        chk("refresh_tick_an", anode_L, 4'hD);

        // 2: static display, multiplex order
        wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
        wait_an(4'hE);
        chk("st_d0_seg", seg_L, 7'b0011001);
        repeat (4) @(negedge clk);
        chk("st_d1_an", anode_L, 4'hD);
        chk("st_d1_seg", seg_L, 7'b0110000);
        repeat (4) @(negedge clk);
        chk("st_d2_an", anode_L, 4'hB);
        chk("st_d2_seg", seg_L, 7'b0100100);
        repeat (4) @(negedge clk);
        chk("st_d3_an", anode_L, 4'h7);
        chk("st_d3_seg", seg_L, 7'b1111001);
        en = 1'b1;
        wait_stick(3);
        left_seg(s);
        chk("st_hold_left", s, 7'b1111001);
        wait_an(4'hE);
        chk("st_hold_d0", seg_L, 7'b0011001);

        // glyph table, offset 0 so buf[0] sits on the leftmost digit
        en = 1'b0;
        for (int i = 0; i < 21; i++) begin
            wr(0, int'(vecs[i].code));
            left_seg(s);
            chk($sformatf("glyph_%0d", vecs[i].code), s, vecs[i].seg);
        end

        // 3: scroll left / wrap / scroll right
        for (int i = 0; i < 8; i++) wr(i, i);
        mode = 2'b01; en = 1'b1;
        wait_stick(1);
        en = 1'b0;
        left_seg(s);
        chk("scrl_left_1", s, ref_glyph(1));
        en = 1'b1;
        wait_stick(7);
        en = 1'b0;
        left_seg(s);
        chk("scrl_wrap_0", s, ref_glyph(0));
        mode = 2'b10; en = 1'b1;
        wait_stick(1);
        en = 1'b0;
        left_seg(s);
        chk("scrr_wrap_7", s, ref_glyph(7));
        wait_an(4'hE);
        chk("scrr_d0_buf2", seg_L, ref_glyph(2));

        // 4: blink windows and leaving blink while blanked
        mode = 2'b11; en = 1'b1;
        wait_stick(1);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk("blink_off_an", anode_L, 4'hF);
            chk("blink_off_seg", seg_L, 7'h7F);
            repeat (5) @(negedge clk);
        end
        wait_stick(1);
        @(negedge clk);
        chk("blink_on_visible", anode_L == 4'hF, 1'b0);
        left_seg(s);
        chk("blink_on_left", s, ref_glyph(7));
        wait_stick(1);
        @(negedge clk);
        mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            chk("blink_exit_still_off", anode_L, 4'hF);
            repeat (7) @(negedge clk);
        end
        wait_stick(1);
        @(negedge clk);
        chk("blink_exit_resumed", anode_L == 4'hF, 1'b0);

        // 5: en=0 freezes offset, multiplexing continues
        mode = 2'b01; en = 1'b0;
        seen = 4'h0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            seen = seen | ~anode_L;
        end
        chk("en0_all_digits", seen, 4'hF);
        left_seg(s);
        chk("en0_offset_frozen", s, ref_glyph(7));

        // 6: reset mid-scroll with concurrent write
        en = 1'b1;
        wait_stick(2);
        rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 5'd5;
        @(negedge clk);
        chk("midrst_seg", seg_L, 7'h7F);
        chk("midrst_an", anode_L, 4'hF);
        rst = 1'b0; wr_en = 1'b0; mode = 2'b00; en = 1'b0;
        wait_an(4'hE);
        chk("midrst_addr3_blank", seg_L, 7'h7F);
        wr(0, 8);
        left_seg(s);
        chk("midrst_offset0", s, 7'b0000000);

        // randomized phase, checked by the model every cycle
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 399) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 79) == 0) en = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
